// File: rtl/branch_ctrl.sv
// Branch resolution sequencer for the ID stage of the pipelined MIPS core.
// Stalls ID until the forwarded operands arrive, latches them together with the
// branch type and target, then resolves the branch in a single RESOLVE cycle
// that emits a one-cycle redirect. Also keeps saturating statistics counters
// and a sticky flag for branches whose operands took too long to arrive.
module branch_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             br_valid,
  input  logic [2:0]       br_type,
  input  logic             rs_ready,
  input  logic             rt_ready,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic [31:0]      pc_id,
  input  logic [15:0]      imm16,
  output logic             stall_id,
  output logic             br_done,
  output logic             br_taken,
  output logic [31:0]      br_target,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             wait_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  localparam int WC_W = $clog2(MAX_WAIT + 1) + 1;
  localparam logic [WC_W-1:0]  WAIT_MAX  = WC_W'(MAX_WAIT);
  localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  localparam logic [2:0] T_BEQ  = 3'd0;
  localparam logic [2:0] T_BNE  = 3'd1;
  localparam logic [2:0] T_BLEZ = 3'd2;
  localparam logic [2:0] T_BGTZ = 3'd3;
  localparam logic [2:0] T_BLTZ = 3'd4;
  localparam logic [2:0] T_BGEZ = 3'd5;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              wait_err_q, wait_err_d;
  logic [31:0]       rs_q, rt_q, target_q;
  logic [2:0]        type_q;
  logic [CNT_W-1:0]  taken_cnt_q, ntaken_cnt_q, stall_cnt_q;
  logic              latch_en;
  logic              need_rt;
  logic              ops_ok;
  logic              cond;
  logic [31:0]       target_calc;

  // Operand availability and the branch target for the instruction now in ID
  always_comb begin
    need_rt     = (br_type <= T_BNE);
    ops_ok      = rs_ready & (rt_ready | ~need_rt);
    target_calc = pc_id + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
  end

  // State and wait-timer register; reset returns to IDLE with nothing pending
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      wait_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wait_err_q <= wait_err_d;
    end
  end

  // Next-state logic; a flush overrides every transition and freezes the timer
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wait_err_d = wait_err_q;
    latch_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (br_valid) begin
          if (ops_ok) begin
            state_d  = RESOLVE;
            latch_en = 1'b1;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = '0;
          end
        end
      end
      WAIT: begin
        if (ops_ok) begin
          state_d  = RESOLVE;
          latch_en = 1'b1;
        end else begin
          if (wait_cnt_q < WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q >= WAIT_LAST) wait_err_d = 1'b1;
        end
      end
      RESOLVE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d    = IDLE;
      wait_cnt_d = wait_cnt_q;
      wait_err_d = wait_err_q;
      latch_en   = 1'b0;
    end
  end

  // Operand/type/target latches captured when the branch moves to RESOLVE
  always_ff @(posedge clk) begin
    if (reset) begin
      rs_q     <= '0;
      rt_q     <= '0;
      type_q   <= '0;
      target_q <= '0;
    end else if (latch_en) begin
      rs_q     <= rs_data;
      rt_q     <= rt_data;
      type_q   <= br_type;
      target_q <= target_calc;
    end
  end

  // Branch condition evaluated on the latched operands, all compares signed
  always_comb begin
    cond = 1'b0;
    case (type_q)
      T_BEQ:   cond = (rs_q == rt_q);
      T_BNE:   cond = (rs_q != rt_q);
      T_BLEZ:  cond = ($signed(rs_q) <= 0);
      T_BGTZ:  cond = ($signed(rs_q) > 0);
      T_BLTZ:  cond = ($signed(rs_q) < 0);
      T_BGEZ:  cond = ($signed(rs_q) >= 0);
      default: cond = 1'b0;
    endcase
  end

  // Stall and redirect outputs; flush and reset silence them in the same cycle
  always_comb begin
    stall_id = 1'b0;
    br_done  = 1'b0;
    case (state_q)
      IDLE:    stall_id = br_valid;
      WAIT:    stall_id = 1'b1;
      RESOLVE: br_done  = 1'b1;
      default: stall_id = 1'b0;
    endcase
    if (flush || reset) begin
      stall_id = 1'b0;
      br_done  = 1'b0;
    end
    br_taken  = br_done & cond;
    br_target = target_q;
    wait_err  = wait_err_q;
  end

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt_q  <= '0;
      ntaken_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (stall_id && stall_cnt_q != CNT_MAX) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (br_done) begin
        if (cond) begin
          if (taken_cnt_q != CNT_MAX) taken_cnt_q <= taken_cnt_q + 1'b1;
        end else begin
          if (ntaken_cnt_q != CNT_MAX) ntaken_cnt_q <= ntaken_cnt_q + 1'b1;
        end
      end
    end
  end

  assign taken_cnt  = taken_cnt_q;
  assign ntaken_cnt = ntaken_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
